// File: rtl/asym_fifo_pkg.sv
// Shared constants and elaboration-time helpers for the asymmetric (wide-in / narrow-out) FIFO.
package asym_fifo_pkg;

  localparam int unsigned DEF_WIDTH_IN  = 64;
  localparam int unsigned DEF_WIDTH_OUT = 8;
  localparam int unsigned DEF_DEPTH_IN  = 32;

  function automatic int unsigned clog2u(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < v; p = p << 1) r++;
    return r;
  endfunction

  function automatic logic is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

  // Legal geometry: integer ratio, ratio and depth both powers of two and at least 2.
  function automatic logic geometry_ok(input int unsigned width_in,
                                       input int unsigned width_out,
                                       input int unsigned depth_in);
    if (width_out == 0) return 1'b0;
    if ((width_in % width_out) != 0) return 1'b0;
    if (!is_pow2(width_in / width_out) || (width_in / width_out) < 2) return 1'b0;
    return is_pow2(depth_in) && (depth_in >= 2);
  endfunction

endpackage

// File: rtl/asym_fifo_ctrl_if.sv
// Write/read handshake bundle for asym_fifo_ctrl; the controller uses the slave modport.
interface asym_fifo_ctrl_if
  import asym_fifo_pkg::*;
#(
  parameter int unsigned WIDTH_IN  = DEF_WIDTH_IN,
  parameter int unsigned WIDTH_OUT = DEF_WIDTH_OUT,
  parameter int unsigned DEPTH_IN  = DEF_DEPTH_IN
);
  localparam int unsigned LEVEL_WIDTH = clog2u(DEPTH_IN * (WIDTH_IN / WIDTH_OUT)) + 1;

  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH_IN-1:0]    in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH_OUT-1:0]   out_data;
  logic [LEVEL_WIDTH-1:0] level;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, level
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, level
  );

endinterface

// File: rtl/asym_fifo_storage.sv
// Distributed RAM: wide synchronous write, narrow asynchronous read addressed as {word, lane}.
module asym_fifo_storage
  import asym_fifo_pkg::*;
#(
  parameter int unsigned WIDTH_IN  = DEF_WIDTH_IN,
  parameter int unsigned WIDTH_OUT = DEF_WIDTH_OUT,
  parameter int unsigned DEPTH_IN  = DEF_DEPTH_IN
) (
  input  logic                                           clk,
  input  logic                                           wr_en,
  input  logic [clog2u(DEPTH_IN)-1:0]                    wr_addr,
  input  logic [WIDTH_IN-1:0]                            wr_data,
  input  logic [clog2u(DEPTH_IN*(WIDTH_IN/WIDTH_OUT))-1:0] rd_addr,
  output logic [WIDTH_OUT-1:0]                           rd_data
);
  localparam int unsigned RATIO        = WIDTH_IN / WIDTH_OUT;
  localparam int unsigned LOG2_RATIO   = clog2u(RATIO);
  localparam int unsigned ADDR_B_WIDTH = clog2u(DEPTH_IN * RATIO);

  logic [RATIO-1:0][WIDTH_OUT-1:0] mem [DEPTH_IN];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_comb begin
    rd_data = mem[rd_addr[ADDR_B_WIDTH-1:LOG2_RATIO]][rd_addr[LOG2_RATIO-1:0]];
  end

endmodule

// File: rtl/asym_fifo_ctrl.sv
// Wide-in / narrow-out FIFO controller: pointers, full/empty, fill level and slice order.
// Optional macro ASYM_FIFO_MSB_FIRST_EN emits the most-significant slice of each word first.
module asym_fifo_ctrl
  import asym_fifo_pkg::*;
#(
  parameter int unsigned WIDTH_IN  = DEF_WIDTH_IN,
  parameter int unsigned WIDTH_OUT = DEF_WIDTH_OUT,
  parameter int unsigned DEPTH_IN  = DEF_DEPTH_IN
) (
  input  logic             clk,
  input  logic             rst,
  asym_fifo_ctrl_if.slave  bus
);
  localparam int unsigned RATIO        = WIDTH_IN / WIDTH_OUT;
  localparam int unsigned DEPTH_OUT    = DEPTH_IN * RATIO;
  localparam int unsigned ADDR_A_WIDTH = clog2u(DEPTH_IN);
  localparam int unsigned ADDR_B_WIDTH = clog2u(DEPTH_OUT);
  localparam int unsigned LOG2_RATIO   = clog2u(RATIO);

  if (!geometry_ok(WIDTH_IN, WIDTH_OUT, DEPTH_IN)) begin : g_bad_geometry
    $error("asym_fifo_ctrl: WIDTH_IN must be a power-of-2 multiple (>=2) of WIDTH_OUT and DEPTH_IN a power of 2 (>=2)");
  end

  logic [ADDR_A_WIDTH:0]   wr_ptr;
  logic [ADDR_B_WIDTH:0]   rd_ptr;
  logic [ADDR_A_WIDTH:0]   rd_word;
  logic [ADDR_A_WIDTH:0]   wide_count;
  logic [LOG2_RATIO-1:0]   lane;
  logic [LOG2_RATIO-1:0]   lane_sel;
  logic [ADDR_B_WIDTH-1:0] rd_addr;
  logic                    full;
  logic                    empty;
  logic                    wr_en;
  logic                    rd_en;

  // Flags compare at wide granularity, so a partly read word keeps its slot until its last lane goes.
  always_comb begin
    rd_word    = rd_ptr[ADDR_B_WIDTH:LOG2_RATIO];
    lane       = rd_ptr[LOG2_RATIO-1:0];
    full       = (wr_ptr[ADDR_A_WIDTH] != rd_word[ADDR_A_WIDTH]) &&
                 (wr_ptr[ADDR_A_WIDTH-1:0] == rd_word[ADDR_A_WIDTH-1:0]);
    empty      = (wr_ptr == rd_word);
    wr_en      = bus.in_valid && !full;
    rd_en      = bus.out_ready && !empty;
    wide_count = wr_ptr - rd_word;
`ifdef ASYM_FIFO_MSB_FIRST_EN
    lane_sel   = ~lane;
`else
    lane_sel   = lane;
`endif
    rd_addr    = {rd_word[ADDR_A_WIDTH-1:0], lane_sel};
  end

  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;
  assign bus.level     = {wide_count, {LOG2_RATIO{1'b0}}} - {{(ADDR_A_WIDTH+1){1'b0}}, lane};

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (ADDR_A_WIDTH+1)'(1);
      if (rd_en) rd_ptr <= rd_ptr + (ADDR_B_WIDTH+1)'(1);
    end
  end

  asym_fifo_storage #(
    .WIDTH_IN  (WIDTH_IN),
    .WIDTH_OUT (WIDTH_OUT),
    .DEPTH_IN  (DEPTH_IN)
  ) u_storage (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr[ADDR_A_WIDTH-1:0]),
    .wr_data (bus.in_data),
    .rd_addr (rd_addr),
    .rd_data (bus.out_data)
  );

endmodule

// File: tb/tb_asym_fifo_ctrl.sv
// Scoreboard bench for asym_fifo_ctrl: accepted writes queue their slices, a monitor pops and compares.
module tb_asym_fifo_ctrl;
  import asym_fifo_pkg::*;

  localparam int unsigned WI = 64;
  localparam int unsigned WO = 8;
  localparam int unsigned DI = 32;
  localparam int unsigned R  = WI / WO;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  asym_fifo_ctrl_if #(.WIDTH_IN(WI), .WIDTH_OUT(WO), .DEPTH_IN(DI)) bus ();

  asym_fifo_ctrl #(.WIDTH_IN(WI), .WIDTH_OUT(WO), .DEPTH_IN(DI)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int unsigned vectors = 0;
  int unsigned errors  = 0;
  logic [WO-1:0] exp_q[$];
  logic          mon_en = 1'b0;
  logic          stall_prev = 1'b0;
  logic [WO-1:0] held;
  int unsigned   sz;
  int unsigned   words;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Slice at stream position idx of a wide word (0 = emitted first).
  function automatic logic [WO-1:0] slice_at(input logic [WI-1:0] w, input int unsigned idx);
`ifdef ASYM_FIFO_MSB_FIRST_EN
    return w[(R-1-idx)*WO +: WO];
`else
    return w[idx*WO +: WO];
`endif
  endfunction

  // Monitor: checks outputs against the queue state before this cycle's edge, then applies transfers.
  always @(negedge clk) begin
    if (mon_en) begin
      sz    = exp_q.size();
      words = (sz + R - 1) / R;
      check("out_valid", 64'(bus.out_valid), 64'(sz != 0));
      check("in_ready",  64'(bus.in_ready),  64'(words < DI));
      check("level",     64'(bus.level),     64'(sz));
      if (bus.out_valid && sz != 0) check("out_data", 64'(bus.out_data), 64'(exp_q[0]));
      if (stall_prev && bus.out_valid) check("stall_hold", 64'(bus.out_data), 64'(held));
      stall_prev = bus.out_valid && !bus.out_ready;
      held       = bus.out_data;
      if (rst) begin
        exp_q.delete();
        stall_prev = 1'b0;
      end else begin
        if (bus.out_valid && bus.out_ready && sz != 0) void'(exp_q.pop_front());
        if (bus.in_valid && bus.in_ready)
          for (int unsigned i = 0; i < R; i++) exp_q.push_back(slice_at(bus.in_data, i));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 400 && bus.out_valid; c++) cyc();
    check("drain_empty", 64'(bus.out_valid), 64'd0);
    bus.out_ready = 1'b0;
  endtask

  logic [WI-1:0] w;
  int unsigned   accepted;

  initial begin
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (3) cyc();
    rst    = 1'b0;
    mon_en = 1'b1;
    check("reset_out_valid", 64'(bus.out_valid), 64'd0);
    check("reset_level",     64'(bus.level),     64'd0);
    check("reset_in_ready",  64'(bus.in_ready),  64'd1);

    // Single word streamed out with out_ready held high.
    w = 64'h0807060504030201;
    bus.in_data = w; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    cyc();
    bus.in_valid = 1'b0;
    check("t1_valid_latency", 64'(bus.out_valid), 64'd1);
    check("t1_level_full",    64'(bus.level),     64'd8);
`ifdef ASYM_FIFO_MSB_FIRST_EN
    check("t1_first_slice",   64'(bus.out_data),  64'h08);
`else
    check("t1_first_slice",   64'(bus.out_data),  64'h01);
`endif
    repeat (9) cyc();
    check("t1_level_end", 64'(bus.level), 64'd0);

    // Fill to capacity with no reads, then offer extra words.
    bus.out_ready = 1'b0; bus.in_valid = 1'b1;
    for (int i = 0; i < 32; i++) begin
      bus.in_data = {$urandom, $urandom};
      cyc();
    end
    check("t2_level_full", 64'(bus.level),    64'd256);
    check("t2_in_ready",   64'(bus.in_ready), 64'd0);
    bus.in_data = {$urandom, $urandom};
    cyc(); cyc();
    check("t2_level_ignored", 64'(bus.level), 64'd256);
    bus.in_valid = 1'b0;

    // Partial word read keeps the slot occupied; last lane frees it for the following cycle.
    bus.out_ready = 1'b1;
    repeat (7) cyc();
    bus.out_ready = 1'b0;
    check("t3_level_249", 64'(bus.level),    64'd249);
    check("t3_in_ready0", 64'(bus.in_ready), 64'd0);
    bus.in_data = {$urandom, $urandom}; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    cyc();
    bus.out_ready = 1'b0;
    check("t3_in_ready1", 64'(bus.in_ready), 64'd1);
    check("t3_level_248", 64'(bus.level),    64'd248);
    cyc();
    bus.in_valid = 1'b0;
    check("t3_level_256", 64'(bus.level),    64'd256);

    // Random streaming across pointer wrap with consumer stalls.
    accepted = 0;
    for (int c = 0; c < 6000 && accepted < 100; c++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_data   = {$urandom, $urandom};
      bus.out_ready = ($urandom_range(0, 2) != 0);
      if (bus.in_valid && bus.in_ready) accepted++;
      cyc();
    end
    check("t4_accepted", 64'(accepted), 64'd100);
    drain();

    // Reset with 3 words plus 4 lanes read discards everything.
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_data = {$urandom, $urandom};
      cyc();
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    repeat (4) cyc();
    bus.out_ready = 1'b0;
    check("t5_level_20", 64'(bus.level), 64'd20);
    rst = 1'b1; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    cyc();
    rst = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    check("t5_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("t5_rst_level",     64'(bus.level),     64'd0);
    check("t5_rst_in_ready",  64'(bus.in_ready),  64'd1);
    w = {$urandom, $urandom};
    bus.in_data = w; bus.in_valid = 1'b1;
    cyc();
    bus.in_valid = 1'b0;
    check("t5_first_after_rst", 64'(bus.out_data), 64'(slice_at(w, 0)));
    check("t5_level_8",         64'(bus.level),    64'd8);
    drain();

    repeat (2) cyc();
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
